// File: rtl/fold_pkg.sv
// Shared constants and types for the fold arbiter.
//   FOLD_IN_W  : width of one requester operand
//   FOLD_OUT_W : width of a folded result
//   FOLD_NREQ  : default number of requesters
//   fold_id_t  : requester index type for the default configuration
package fold_pkg;

    localparam int unsigned FOLD_IN_W  = 64;
    localparam int unsigned FOLD_OUT_W = 32;
    localparam int unsigned FOLD_NREQ  = 4;
    localparam int unsigned FOLD_ID_W  = $clog2(FOLD_NREQ);

    typedef logic [FOLD_ID_W-1:0] fold_id_t;

endpackage

// File: rtl/fold64.sv
// Combinational 64->32 XOR fold: bit k of the result is in[k] ^ in[k+32].
// Ports:
//   data_i : 64-bit operand
//   data_o : 32-bit folded result
module fold64
    import fold_pkg::*;
(
    input  logic [FOLD_IN_W-1:0]  data_i,
    output logic [FOLD_OUT_W-1:0] data_o
);

    assign data_o = data_i[FOLD_OUT_W-1:0] ^ data_i[FOLD_IN_W-1:FOLD_OUT_W];

endmodule

// File: rtl/fold_arbiter.sv
// Round-robin arbiter feeding a single registered fold stage.
// One requester is granted per cycle when the output register can accept a
// new value; its operands are folded and the result is presented one cycle
// later together with the requester index.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : per-requester request valid
//   req_ready  : per-requester accept (one-hot or zero)
//   req_a/b    : packed 64-bit operands, requester i at [64*i +: 64]
//   out_valid  : folded result valid
//   out_ready  : downstream accept
//   out_aa/bb  : folded operands of the served requester
//   out_id     : index of the served requester
//   grant_cnt  : saturating count of request handshakes
module fold_arbiter
    import fold_pkg::*;
#(
    parameter int unsigned NREQ  = FOLD_NREQ,
    parameter int unsigned CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*FOLD_IN_W-1:0] req_a,
    input  logic [NREQ*FOLD_IN_W-1:0] req_b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [FOLD_OUT_W-1:0]     out_aa,
    output logic [FOLD_OUT_W-1:0]     out_bb,
    output logic [$clog2(NREQ)-1:0]   out_id,
    output logic [CNT_W-1:0]          grant_cnt
);

    localparam int unsigned ID_W = $clog2(NREQ);

    logic                  out_valid_q;
    logic [FOLD_OUT_W-1:0] out_aa_q;
    logic [FOLD_OUT_W-1:0] out_bb_q;
    logic [ID_W-1:0]       out_id_q;
    logic [ID_W-1:0]       ptr_q;
    logic [CNT_W-1:0]      grant_cnt_q;

    logic                  can_load;
    logic                  any_grant;
    logic                  handshake;
    logic [ID_W-1:0]       grant_id;
    logic [ID_W-1:0]       scan_idx;
    logic [NREQ-1:0]       grant;
    logic [FOLD_IN_W-1:0]  sel_a;
    logic [FOLD_IN_W-1:0]  sel_b;
    logic [FOLD_OUT_W-1:0] fold_a;
    logic [FOLD_OUT_W-1:0] fold_b;

    assign can_load = !out_valid_q || out_ready;

    // Scan from ptr in cyclic order; NREQ is a power of two so the ID_W-bit
    // sum wraps around naturally.
    always_comb begin
        any_grant = 1'b0;
        grant_id  = '0;
        scan_idx  = '0;
        grant     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = ptr_q + ID_W'(k);
            if (!any_grant && req_valid[scan_idx]) begin
                any_grant = 1'b1;
                grant_id  = scan_idx;
            end
        end
        grant[grant_id] = any_grant;
    end

    // Reset blocks accepts so nothing is consumed that would be discarded.
    assign req_ready = (can_load && !rst) ? grant : '0;
    assign handshake = can_load && any_grant;

    assign sel_a = req_a[grant_id*FOLD_IN_W +: FOLD_IN_W];
    assign sel_b = req_b[grant_id*FOLD_IN_W +: FOLD_IN_W];

    fold64 u_fold_a (
        .data_i (sel_a),
        .data_o (fold_a)
    );

    fold64 u_fold_b (
        .data_i (sel_b),
        .data_o (fold_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_aa_q    <= '0;
            out_bb_q    <= '0;
            out_id_q    <= '0;
            ptr_q       <= '0;
            grant_cnt_q <= '0;
        end else begin
            if (can_load) begin
                // A drain with no new winner empties the stage.
                out_valid_q <= any_grant;
            end
            if (handshake) begin
                out_aa_q <= fold_a;
                out_bb_q <= fold_b;
                out_id_q <= grant_id;
                ptr_q    <= grant_id + 1'b1;
                if (grant_cnt_q != '1) begin
                    grant_cnt_q <= grant_cnt_q + 1'b1;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_aa    = out_aa_q;
    assign out_bb    = out_bb_q;
    assign out_id    = out_id_q;
    assign grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_fold_arbiter.sv
module tb_fold_arbiter;

    localparam int NREQ  = 4;
    localparam int CNT_W = 16;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*64-1:0]   req_a;
    logic [NREQ*64-1:0]   req_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_aa;
    logic [31:0]          out_bb;
    logic [1:0]           out_id;
    logic [CNT_W-1:0]     grant_cnt;

    // Narrow-counter instance for saturation
    logic                 s_rst;
    logic [1:0]           s_req_valid;
    logic [1:0]           s_req_ready;
    logic [127:0]         s_req_a;
    logic [127:0]         s_req_b;
    logic                 s_out_valid;
    logic                 s_out_ready;
    logic [31:0]          s_out_aa;
    logic [31:0]          s_out_bb;
    logic                 s_out_id;
    logic [1:0]           s_grant_cnt;

    fold_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_aa    (out_aa),
        .out_bb    (out_bb),
        .out_id    (out_id),
        .grant_cnt (grant_cnt)
    );

    fold_arbiter #(.NREQ(2), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst       (s_rst),
        .req_valid (s_req_valid),
        .req_ready (s_req_ready),
        .req_a     (s_req_a),
        .req_b     (s_req_b),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_aa    (s_out_aa),
        .out_bb    (s_out_bb),
        .out_id    (s_out_id),
        .grant_cnt (s_grant_cnt)
    );

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_valid = 1'b0;
    int          m_ptr   = 0;
    int          m_id    = 0;
    int          m_cnt   = 0;
    logic [31:0] m_aa    = '0;
    logic [31:0] m_bb    = '0;

    function automatic logic [31:0] fold(input logic [63:0] x);
        return x[31:0] ^ x[63:32];
    endfunction

    // First valid requester at or after ptr in cyclic order, -1 if none.
    function automatic int pick(input int ptr, input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (ptr + k) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : model
        int g;
        if (rst) begin
            m_valid = 1'b0;
            m_ptr   = 0;
            m_id    = 0;
            m_cnt   = 0;
            m_aa    = '0;
            m_bb    = '0;
        end else if (!m_valid || out_ready) begin
            g = pick(m_ptr, req_valid);
            if (g >= 0) begin
                m_valid = 1'b1;
                m_aa    = fold(req_a[g*64 +: 64]);
                m_bb    = fold(req_b[g*64 +: 64]);
                m_id    = g;
                m_ptr   = (g + 1) % NREQ;
                if (m_cnt < CMAX) m_cnt++;
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        int g;
        logic [63:0] exp_rdy;
        if (cmp_en) begin
            exp_rdy = 64'd0;
            g = pick(m_ptr, req_valid);
            if (!rst && (!m_valid || out_ready) && g >= 0) exp_rdy = 64'd1 << g;
            chk("m_req_ready", 64'(req_ready), exp_rdy);
            chk("m_out_valid", 64'(out_valid), 64'(m_valid));
            chk("m_grant_cnt", 64'(grant_cnt), 64'(m_cnt));
            if (m_valid) begin
                chk("m_out_aa", 64'(out_aa), 64'(m_aa));
                chk("m_out_bb", 64'(out_bb), 64'(m_bb));
                chk("m_out_id", 64'(out_id), 64'(m_id));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*64 +: 64] = {$urandom, $urandom};
            req_b[i*64 +: 64] = {$urandom, $urandom};
        end
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = '0;
        out_ready   = 1'b1;
        rand_data();
        s_rst       = 1'b1;
        s_req_valid = 2'b11;
        s_out_ready = 1'b1;
        s_req_a     = {4{$urandom}};
        s_req_b     = {4{$urandom}};

        // Reset state
        @(posedge clk);
        cmp_en = 1'b1;
        #2;
        req_valid = '1;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_grant_cnt", 64'(grant_cnt), 64'd0);
        chk("rst_out_id",    64'(out_id),    64'd0);
        chk("rst_out_aa",    64'(out_aa),    64'd0);

        // Round-robin sweep with all requesters valid
        req_a[63:0] = 64'hFFFF0000_0000FFFF;
        req_b[63:0] = 64'h12345678_12345678;
        rst = 1'b0;
        #1;
        chk("rr_first_ready", 64'(req_ready), 64'd1);
        for (int g = 1; g <= 5; g++) begin
            cyc();
            #1;
            chk("rr_out_valid", 64'(out_valid), 64'd1);
            chk("rr_out_id", 64'(out_id), 64'((g - 1) % 4));
            if (g < 5) chk("rr_ready", 64'(req_ready), 64'd1 << (g % 4));
        end
        chk("rr_grant_cnt", 64'(grant_cnt), 64'd5);
        chk("fold_aa", 64'(out_aa), 64'h0000_0000_FFFF_FFFF);
        chk("fold_bb", 64'(out_bb), 64'd0);

        // Backpressure: outputs frozen, no accepts
        out_ready = 1'b0;
        #1;
        chk("bp_ready0", 64'(req_ready), 64'd0);
        repeat (3) begin
            cyc();
            #1;
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_id", 64'(out_id), 64'd0);
            chk("bp_out_aa", 64'(out_aa), 64'h0000_0000_FFFF_FFFF);
            chk("bp_ready", 64'(req_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(req_ready), 64'b0010);
        cyc();
        #1;
        chk("bp_release_id", 64'(out_id), 64'd1);
        chk("bp_release_cnt", 64'(grant_cnt), 64'd6);

        // Lone requester 2, then again with ptr already past it
        req_valid = 4'b0100;
        #1;
        chk("lone_ready_a", 64'(req_ready), 64'b0100);
        cyc();
        #1;
        chk("lone_id_a", 64'(out_id), 64'd2);
        chk("lone_ready_b", 64'(req_ready), 64'b0100);
        cyc();
        #1;
        chk("lone_id_b", 64'(out_id), 64'd2);
        req_valid = 4'b1111;
        #1;
        chk("ptr_after_lone", 64'(req_ready), 64'b1000);
        cyc();
        #1;
        chk("ptr_after_id", 64'(out_id), 64'd3);

        // Drain with nothing pending
        req_valid = '0;
        #1;
        chk("idle_ready", 64'(req_ready), 64'd0);
        cyc();
        #1;
        chk("drain_valid", 64'(out_valid), 64'd0);

        // Reset while a result is pending
        req_valid = 4'b0001;
        cyc();
        #1;
        chk("pend_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        req_valid = '1;
        #1;
        chk("midrst_ready", 64'(req_ready), 64'd0);
        cyc();
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_cnt", 64'(grant_cnt), 64'd0);
        chk("midrst_id", 64'(out_id), 64'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk("postrst_ready", 64'(req_ready), 64'd1);
        cyc();
        #1;
        chk("postrst_id", 64'(out_id), 64'd0);
        chk("postrst_cnt", 64'(grant_cnt), 64'd1);

        // Randomized traffic against the model
        repeat (3000) begin
            cyc();
            req_valid = NREQ'($urandom);
            out_ready = ($urandom_range(3) != 0);
            rst       = ($urandom_range(199) == 0);
            rand_data();
        end
        cyc();
        rst = 1'b0;

        // Counter saturation on a 2-bit instance
        s_rst = 1'b0;
        cyc();
        #1;
        chk("sat_cnt1", 64'(s_grant_cnt), 64'd1);
        chk("sat_id1", 64'(s_out_id), 64'd0);
        cyc();
        #1;
        chk("sat_cnt2", 64'(s_grant_cnt), 64'd2);
        chk("sat_id2", 64'(s_out_id), 64'd1);
        cyc();
        #1;
        chk("sat_cnt3", 64'(s_grant_cnt), 64'd3);
        cyc();
        #1;
        chk("sat_cnt4", 64'(s_grant_cnt), 64'd3);
        cyc();
        #1;
        chk("sat_cnt5", 64'(s_grant_cnt), 64'd3);
        chk("sat_valid", 64'(s_out_valid), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fold_arbiter.md
FOLD_ARBITER -- requirements
Module: fold_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (power of 2, 2..8).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the grant counter.
REQ-003 The block SHALL use one clock, clk, with a synchronous, active-high reset, rst, as already decided.
REQ-004 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept, at most one bit high per cycle
- req_a  input  NREQ*64  operand a; requester i occupies bits [64*i+63:64*i]
- req_b  input  NREQ*64  operand b; same packing as req_a
- out_valid  output  1  folded result valid
- out_ready  input  1  downstream accept
- out_aa  output  32  fold of granted a
- out_bb  output  32  fold of granted b
- out_id  output  log2(NREQ)  index of the served requester
- grant_cnt  output  CNT_W  total grants, saturating

Function
REQ-005 The fold SHALL be out_aa[k] = a[k] XOR a[k+32] and out_bb[k] = b[k] XOR b[k+32], for k = 0..31.
REQ-006 The load condition SHALL be can_load = !out_valid || out_ready.
REQ-007 Arbitration SHALL be round-robin: starting at pointer ptr, the first i in cyclic order with req_valid[i]=1 is granted.
REQ-008 req_ready[i] SHALL equal can_load AND grant[i]; it is combinational and has no dependency on out_ready beyond can_load.
REQ-009 On a handshake with requester i, the next cycle SHALL hold out_valid=1, the fold of req_a[i]/req_b[i], and out_id=i; ptr becomes (i+1) mod NREQ.
REQ-010 Latency from request handshake to out_valid SHALL be exactly 1 cycle.
REQ-011 While out_valid=1 and out_ready=0, out_aa, out_bb and out_id SHALL hold stable, and all req_ready bits SHALL be 0.
REQ-012 If out_valid=1, out_ready=1 and no request is valid, out_valid SHALL drop to 0 in the next cycle.
REQ-013 A simultaneous drain and load SHALL replace the output register, sustaining 1 result per cycle.
REQ-014 ptr SHALL be unchanged in any cycle without a handshake.
REQ-015 grant_cnt SHALL increment by 1 per request handshake and saturate at 2^CNT_W-1.
REQ-016 When a single requester is valid, it SHALL be granted regardless of ptr.
REQ-017 For any continuously valid requester, the worst-case wait SHALL be NREQ-1 grants to other requesters.

Reset
REQ-018 While rst=1, out_valid SHALL be 0; out_aa, out_bb, out_id, ptr and grant_cnt SHALL be 0; and req_ready SHALL be all-zero.
REQ-019 Reset mid-operation SHALL discard any pending output without emitting it.
REQ-020 After rst deasserts, arbitration SHALL start at requester 0.

Structure
REQ-021 The shared package fold_pkg SHALL hold FOLD_IN_W=64, FOLD_OUT_W=32, the default NREQ and the id type.
REQ-022 There SHALL be one sub-module, fold64: the combinational 64->32 XOR fold, instantiated once per operand after the grant mux.
REQ-023 The block SHALL contain registers only for the output stage, ptr and grant_cnt.

Verification
REQ-024 After reset, drive all req_valid=1 with out_ready=1 -> grants SHALL go 0,1,2,3,0 on consecutive cycles, out_id SHALL lag by 1 cycle, and grant_cnt=5 after 5 grants.
REQ-025 Drive req_a[0]=0xFFFF0000_0000FFFF and req_b[0]=0x12345678_12345678 -> out_aa=0xFFFFFFFF and out_bb=0x00000000.
REQ-026 Hold out_ready=0 for 3 cycles with out_valid=1 -> outputs SHALL be stable, req_ready=0; releasing out_ready SHALL load the next winner in the same cycle.
REQ-027 Keep only requester 2 valid with ptr=3 -> requester 2 SHALL be granted immediately, and ptr SHALL become 3.
REQ-028 Assert rst with out_valid=1 -> next cycle out_valid=0, ptr=0 and grant_cnt=0; no stale result SHALL appear.
REQ-029 Force grant_cnt to 0xFFFE and perform 3 grants -> grant_cnt SHALL read 0xFFFF.
